// File: rtl/vds_ctrl_pkg.sv
// Shared register map, bit positions and helpers for the down scaler control block.
package vds_ctrl_pkg;

    // Register byte offsets
    localparam logic [31:0] REG_CTRL      = 32'h00;
    localparam logic [31:0] REG_STATUS    = 32'h04;
    localparam logic [31:0] REG_SRC_W     = 32'h08;
    localparam logic [31:0] REG_SRC_H     = 32'h0C;
    localparam logic [31:0] REG_DST_W     = 32'h10;
    localparam logic [31:0] REG_DST_H     = 32'h14;
    localparam logic [31:0] REG_HLOC_IN   = 32'h18;
    localparam logic [31:0] REG_VLOC_IN   = 32'h1C;
    localparam logic [31:0] REG_HLOC_OUT  = 32'h20;
    localparam logic [31:0] REG_VLOC_OUT  = 32'h24;
    localparam logic [31:0] REG_FRAME_CNT = 32'h28;
    localparam logic [31:0] LOGO_BASE     = 32'h40;
    localparam logic [31:0] LOGO_STRIDE   = 32'h10;

    localparam int MAX_LOGOS = 4;

    // CONTROL bit positions
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_SOFT_RST = 1;
    localparam int CTRL_CONT     = 2;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int CTRL_LOGO_EN  = 8;

    // STATUS bit positions
    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;

    // Merge new_val into old_val one byte lane at a time under the write strobes
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/vds_ctrl_axil_if.sv
// AXI4-Lite slave handshake engine: decoupled AW/W capture, single-beat
// write commit, and a one-cycle-latency registered read path.
module vds_ctrl_axil_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic                      wr_en,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH/8-1:0]   wr_strb,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0]     rd_data
);

    logic                    aw_held_reg;
    logic [ADDR_WIDTH-1:0]   aw_addr_reg;
    logic                    w_held_reg;
    logic [DATA_WIDTH-1:0]   w_data_reg;
    logic [DATA_WIDTH/8-1:0] w_strb_reg;
    logic                    bvalid_reg;
    logic                    rvalid_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    aw_hs;
    logic                    w_hs;

    assign S_AXI_AWREADY = !aw_held_reg && !bvalid_reg;
    assign S_AXI_WREADY  = !w_held_reg && !bvalid_reg;
    assign S_AXI_ARREADY = !rvalid_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

    // Commit as soon as both halves exist, whether held or arriving this cycle
    assign wr_en   = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    assign wr_addr = aw_held_reg ? aw_addr_reg : S_AXI_AWADDR;
    assign wr_data = w_held_reg ? w_data_reg : S_AXI_WDATA;
    assign wr_strb = w_held_reg ? w_strb_reg : S_AXI_WSTRB;

    assign rd_en   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_addr = S_AXI_ARADDR;

    // Write channel capture and response
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            aw_held_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
        end else if (wr_en) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_addr_reg <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= S_AXI_WDATA;
                w_strb_reg <= S_AXI_WSTRB;
            end
            if (bvalid_reg && S_AXI_BREADY) bvalid_reg <= 1'b0;
        end
    end

    // Read data register, held until the master accepts it
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (rd_en) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/vds_ctrl_v2.sv
// Down scaler control/status block: register file, frame-synchronous
// shadowing of geometry and logo windows, sticky done and level irq.
module vds_ctrl_v2
    import vds_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_LOGOS  = 2
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          reset,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          run,
    output logic                          soft_reset,
    input  logic                          done,
    input  logic                          frame_start,
    input  logic [DATA_WIDTH-1:0]         hlocation_in,
    input  logic [DATA_WIDTH-1:0]         vlocation_in,
    input  logic [DATA_WIDTH-1:0]         hlocation_out,
    input  logic [DATA_WIDTH-1:0]         vlocation_out,
    output logic [DATA_WIDTH-1:0]         src_width,
    output logic [DATA_WIDTH-1:0]         src_height,
    output logic [DATA_WIDTH-1:0]         dst_width,
    output logic [DATA_WIDTH-1:0]         dst_height,
    output logic [NUM_LOGOS-1:0]          logo_valid,
    output logic [NUM_LOGOS*DATA_WIDTH-1:0] logo_hbegin,
    output logic [NUM_LOGOS*DATA_WIDTH-1:0] logo_hend,
    output logic [NUM_LOGOS*DATA_WIDTH-1:0] logo_vbegin,
    output logic [NUM_LOGOS*DATA_WIDTH-1:0] logo_vend,
    output logic                          irq
);

    genvar gi;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;

    vds_ctrl_axil_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_axil_if (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    // ---------------- address decode ----------------
    logic [31:0] wr_off, rd_off, wr_rel, rd_rel;
    logic        ctrl_wr, stat_wr;
    logic        wr_logo_hit, rd_logo_hit;
    logic [1:0]  wr_logo_k, wr_logo_r, rd_logo_k, rd_logo_r;

    assign wr_off  = 32'(wr_addr) & 32'hFFFF_FFFC;
    assign rd_off  = 32'(rd_addr) & 32'hFFFF_FFFC;
    assign ctrl_wr = wr_en && (wr_off == REG_CTRL);
    assign stat_wr = wr_en && (wr_off == REG_STATUS);

    // Logo windows occupy a 16-byte block each; windows past NUM_LOGOS are holes
    assign wr_rel      = wr_off - LOGO_BASE;
    assign rd_rel      = rd_off - LOGO_BASE;
    assign wr_logo_k   = wr_rel[5:4];
    assign wr_logo_r   = wr_rel[3:2];
    assign rd_logo_k   = rd_rel[5:4];
    assign rd_logo_r   = rd_rel[3:2];
    assign wr_logo_hit = wr_en && (wr_off >= LOGO_BASE) &&
                         (wr_rel < 32'(MAX_LOGOS) * LOGO_STRIDE) && (int'(wr_logo_k) < NUM_LOGOS);
    assign rd_logo_hit = (rd_off >= LOGO_BASE) &&
                         (rd_rel < 32'(MAX_LOGOS) * LOGO_STRIDE) && (int'(rd_logo_k) < NUM_LOGOS);

    // ---------------- control / status ----------------
    logic                 run_reg, run_next;
    logic                 cont_reg, cont_next;
    logic                 irq_en_reg, irq_en_next;
    logic [NUM_LOGOS-1:0] logo_en_reg, logo_en_next;
    logic                 soft_reset_reg, soft_reset_next;
    logic                 done_reg, done_next;
    logic [31:0]          frame_cnt_reg, frame_cnt_next;
    logic                 irq_reg;
    logic                 shadow_load;

    // Next-state for CONTROL/STATUS/FRAME_CNT; later assignments take priority
    always_comb begin
        run_next        = run_reg;
        cont_next       = cont_reg;
        irq_en_next     = irq_en_reg;
        logo_en_next    = logo_en_reg;
        soft_reset_next = 1'b0;
        done_next       = done_reg;
        frame_cnt_next  = frame_cnt_reg;

        if (stat_wr && wr_strb[0] && wr_data[STAT_DONE]) done_next = 1'b0;
        if (done) begin
            done_next      = 1'b1;
            frame_cnt_next = frame_cnt_reg + 32'd1;
            if (!cont_reg) run_next = 1'b0;
        end
        if (ctrl_wr) begin
            if (wr_strb[0]) begin
                run_next        = wr_data[CTRL_RUN];
                cont_next       = wr_data[CTRL_CONT];
                irq_en_next     = wr_data[CTRL_IRQ_EN];
                soft_reset_next = wr_data[CTRL_SOFT_RST];
            end
            if (wr_strb[1]) logo_en_next = wr_data[CTRL_LOGO_EN +: NUM_LOGOS];
            if (soft_reset_next) begin
                run_next       = 1'b0;
                done_next      = 1'b0;
                frame_cnt_next = '0;
            end
        end
    end

    // Control/status register update; irq tracks the post-update state
    always_ff @(posedge S_AXI_ACLK) begin
        if (reset) begin
            run_reg        <= 1'b0;
            cont_reg       <= 1'b0;
            irq_en_reg     <= 1'b0;
            logo_en_reg    <= '0;
            soft_reset_reg <= 1'b0;
            done_reg       <= 1'b0;
            frame_cnt_reg  <= '0;
            irq_reg        <= 1'b0;
        end else begin
            run_reg        <= run_next;
            cont_reg       <= cont_next;
            irq_en_reg     <= irq_en_next;
            logo_en_reg    <= logo_en_next;
            soft_reset_reg <= soft_reset_next;
            done_reg       <= done_next;
            frame_cnt_reg  <= frame_cnt_next;
            irq_reg        <= irq_en_next & done_next;
        end
    end

    assign run         = run_reg;
    assign soft_reset  = soft_reset_reg;
    assign irq         = irq_reg;
    assign shadow_load = !run_reg || frame_start;

    // ---------------- geometry staging and shadows ----------------
    logic [4*DATA_WIDTH-1:0] geo_stage_flat;
    logic [4*DATA_WIDTH-1:0] geo_act_flat;

    for (gi = 0; gi < 4; gi++) begin : g_geo
        logic [DATA_WIDTH-1:0] stage_reg;
        logic [DATA_WIDTH-1:0] act_reg;
        logic                  hit;

        assign hit = wr_en && (wr_off == REG_SRC_W + 32'(4 * gi));

        // Staging write, and shadow copy taken from the pre-write staging value
        always_ff @(posedge S_AXI_ACLK) begin
            if (reset) begin
                stage_reg <= '0;
                act_reg   <= '0;
            end else begin
                if (hit) stage_reg <= apply_strb(stage_reg, wr_data, wr_strb);
                if (shadow_load) act_reg <= stage_reg;
            end
        end

        assign geo_stage_flat[gi*DATA_WIDTH +: DATA_WIDTH] = stage_reg;
        assign geo_act_flat[gi*DATA_WIDTH +: DATA_WIDTH]   = act_reg;
    end

    assign src_width  = geo_act_flat[0*DATA_WIDTH +: DATA_WIDTH];
    assign src_height = geo_act_flat[1*DATA_WIDTH +: DATA_WIDTH];
    assign dst_width  = geo_act_flat[2*DATA_WIDTH +: DATA_WIDTH];
    assign dst_height = geo_act_flat[3*DATA_WIDTH +: DATA_WIDTH];

    // ---------------- logo windows ----------------
    logic [NUM_LOGOS*4*DATA_WIDTH-1:0] logo_stage_flat;

    for (gi = 0; gi < NUM_LOGOS; gi++) begin : g_logo
        logic [DATA_WIDTH-1:0] stage_reg [4];
        logic [DATA_WIDTH-1:0] act_reg [4];
        logic                  valid_reg;

        // Window bounds staging plus frame-synchronous shadow of bounds and enable
        always_ff @(posedge S_AXI_ACLK) begin
            if (reset) begin
                for (int r = 0; r < 4; r++) begin
                    stage_reg[r] <= '0;
                    act_reg[r]   <= '0;
                end
                valid_reg <= 1'b0;
            end else begin
                for (int r = 0; r < 4; r++) begin
                    if (wr_logo_hit && (wr_logo_k == 2'(gi)) && (wr_logo_r == 2'(r)))
                        stage_reg[r] <= apply_strb(stage_reg[r], wr_data, wr_strb);
                    if (shadow_load) act_reg[r] <= stage_reg[r];
                end
                if (shadow_load) valid_reg <= logo_en_reg[gi];
            end
        end

        assign logo_valid[gi]                              = valid_reg;
        assign logo_hbegin[gi*DATA_WIDTH +: DATA_WIDTH]    = act_reg[0];
        assign logo_hend[gi*DATA_WIDTH +: DATA_WIDTH]      = act_reg[1];
        assign logo_vbegin[gi*DATA_WIDTH +: DATA_WIDTH]    = act_reg[2];
        assign logo_vend[gi*DATA_WIDTH +: DATA_WIDTH]      = act_reg[3];
        assign logo_stage_flat[(gi*4+0)*DATA_WIDTH +: DATA_WIDTH] = stage_reg[0];
        assign logo_stage_flat[(gi*4+1)*DATA_WIDTH +: DATA_WIDTH] = stage_reg[1];
        assign logo_stage_flat[(gi*4+2)*DATA_WIDTH +: DATA_WIDTH] = stage_reg[2];
        assign logo_stage_flat[(gi*4+3)*DATA_WIDTH +: DATA_WIDTH] = stage_reg[3];
    end

    // ---------------- read mux ----------------
    // Unmapped offsets and absent logo windows read as zero
    always_comb begin
        rd_data = '0;
        if (rd_logo_hit) begin
            rd_data = logo_stage_flat[int'({rd_logo_k, rd_logo_r})*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            case (rd_off)
                REG_CTRL: begin
                    rd_data[CTRL_RUN]                    = run_reg;
                    rd_data[CTRL_CONT]                   = cont_reg;
                    rd_data[CTRL_IRQ_EN]                 = irq_en_reg;
                    rd_data[CTRL_LOGO_EN +: NUM_LOGOS]   = logo_en_reg;
                end
                REG_STATUS: begin
                    rd_data[STAT_DONE] = done_reg;
                    rd_data[STAT_BUSY] = run_reg;
                end
                REG_SRC_W:     rd_data = geo_stage_flat[0*DATA_WIDTH +: DATA_WIDTH];
                REG_SRC_H:     rd_data = geo_stage_flat[1*DATA_WIDTH +: DATA_WIDTH];
                REG_DST_W:     rd_data = geo_stage_flat[2*DATA_WIDTH +: DATA_WIDTH];
                REG_DST_H:     rd_data = geo_stage_flat[3*DATA_WIDTH +: DATA_WIDTH];
                REG_HLOC_IN:   rd_data = hlocation_in;
                REG_VLOC_IN:   rd_data = vlocation_in;
                REG_HLOC_OUT:  rd_data = hlocation_out;
                REG_VLOC_OUT:  rd_data = vlocation_out;
                REG_FRAME_CNT: rd_data = frame_cnt_reg;
                default:       rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vds_ctrl_v2.sv
// Self-checking bench for vds_ctrl_v2: scenario tasks with a read scoreboard.
module tb_vds_ctrl_v2;

    logic        S_AXI_ACLK = 1'b0;
    logic        reset;
    logic [7:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [7:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        run;
    logic        soft_reset;
    logic        done;
    logic        frame_start;
    logic [31:0] hlocation_in, vlocation_in, hlocation_out, vlocation_out;
    logic [31:0] src_width, src_height, dst_width, dst_height;
    logic [1:0]  logo_valid;
    logic [63:0] logo_hbegin, logo_hend, logo_vbegin, logo_vend;
    logic        irq;

    int checks = 0;
    int passes = 0;
    logic sr_at_commit;
    logic sr_after;

    typedef struct { logic [7:0] addr; logic [31:0] data; } rd_exp_t;
    rd_exp_t exp_q[$];

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    vds_ctrl_v2 #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_LOGOS(2)) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .run           (run),
        .soft_reset    (soft_reset),
        .done          (done),
        .frame_start   (frame_start),
        .hlocation_in  (hlocation_in),
        .vlocation_in  (vlocation_in),
        .hlocation_out (hlocation_out),
        .vlocation_out (vlocation_out),
        .src_width     (src_width),
        .src_height    (src_height),
        .dst_width     (dst_width),
        .dst_height    (dst_height),
        .logo_valid    (logo_valid),
        .logo_hbegin   (logo_hbegin),
        .logo_hend     (logo_hend),
        .logo_vbegin   (logo_vbegin),
        .logo_vend     (logo_vend),
        .irq           (irq)
    );

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // One AXI write. lag = cycles between AW and W handshakes (0 = same cycle).
    // fs_w / done_w raise frame_start / done in the W handshake cycle.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lag, input bit fs_w, input bit done_w, input bit hold_b);
        int budget;
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        if (lag == 0) begin
            S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
            frame_start = fs_w; done = done_w;
        end
        budget = 0;
        while (!(S_AXI_AWREADY && (lag > 0 || S_AXI_WREADY)) && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) begin
            checks++;
            $display("FAIL write_ready_timeout: awready=%b wready=%b, required 1", S_AXI_AWREADY, S_AXI_WREADY);
        end
        tick();
        S_AXI_AWVALID = 1'b0;
        if (lag == 0) begin
            S_AXI_WVALID = 1'b0; frame_start = 1'b0; done = 1'b0;
        end else begin
            repeat (lag - 1) tick();
            checks++;
            if (S_AXI_BVALID !== 1'b0)
                $display("FAIL bvalid_before_w: got %b, required 0", S_AXI_BVALID);
            else passes++;
            S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
            frame_start = fs_w; done = done_w;
            tick();
            S_AXI_WVALID = 1'b0; frame_start = 1'b0; done = 1'b0;
        end
        sr_at_commit = soft_reset;
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00)
            $display("FAIL bvalid_after_commit@%h: bvalid=%b bresp=%b, required 1/00", a, S_AXI_BVALID, S_AXI_BRESP);
        else passes++;
        $display("write addr=%h data=%h strb=%b lag=%0d", a, d, s, lag);
        if (!hold_b) begin
            S_AXI_BREADY = 1'b1;
            tick();
            S_AXI_BREADY = 1'b0;
            sr_after = soft_reset;
            checks++;
            if (S_AXI_BVALID !== 1'b0)
                $display("FAIL bvalid_drop@%h: got %b, required 0", a, S_AXI_BVALID);
            else passes++;
        end
    endtask

    // One AXI read: expectation pushed with the AR, popped when RVALID shows up
    task automatic axi_read(input logic [7:0] a, input logic [31:0] e);
        rd_exp_t item;
        int budget;
        item.addr = a;
        item.data = e;
        exp_q.push_back(item);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        budget = 0;
        while (!S_AXI_ARREADY && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) begin
            checks++;
            $display("FAIL arready_timeout@%h: got %b, required 1", a, S_AXI_ARREADY);
        end
        tick();
        S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_RVALID !== 1'b1)
            $display("FAIL rvalid_latency@%h: got %b, required 1", a, S_AXI_RVALID);
        else passes++;
        // hold RREADY low for one cycle: data must stay put
        tick();
        item = exp_q.pop_front();
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== item.data || S_AXI_RRESP !== 2'b00)
            $display("FAIL read@%h: rvalid=%b rdata=%h rresp=%b, required 1/%h/00",
                     item.addr, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, item.data);
        else passes++;
        $display("read  addr=%h data=%h", a, S_AXI_RDATA);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1 ||
            S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0)
            $display("FAIL reset_handshake: aw/w/ar/b/r=%b%b%b%b%b, required 11100",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID);
        else passes++;
        checks++;
        if (run !== 1'b0 || irq !== 1'b0 || soft_reset !== 1'b0 || dst_width !== 32'h0 || logo_valid !== 2'b00)
            $display("FAIL reset_outputs: run=%b irq=%b sr=%b dst_w=%h lv=%b, required all 0",
                     run, irq, soft_reset, dst_width, logo_valid);
        else passes++;
        axi_read(8'h00, 32'h0);
        axi_read(8'h28, 32'h0);
        axi_read(8'h18, 32'h0000_1234);
    endtask

    task automatic test_aw_before_w();
        axi_write(8'h08, 32'h280, 4'hF, 3, 0, 0, 0);
        axi_read(8'h08, 32'h280);
        checks++;
        if (src_width !== 32'h280) $display("FAIL src_width_idle_copy: got %h, required 00000280", src_width);
        else passes++;
    endtask

    task automatic test_wstrb();
        axi_write(8'h10, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0, 0);
        axi_read(8'h10, 32'h0000_FFFF);
        axi_write(8'h0C, 32'hAB12_3456, 4'b1000, 1, 0, 0, 0);
        axi_read(8'h0C, 32'hAB00_0000);
    endtask

    task automatic test_done_irq();
        axi_write(8'h00, 32'h11, 4'hF, 0, 0, 0, 0);
        checks++;
        if (run !== 1'b1) $display("FAIL run_set: got %b, required 1", run);
        else passes++;
        pulse_done();
        checks++;
        if (run !== 1'b0 || irq !== 1'b1) $display("FAIL done_single_shot: run=%b irq=%b, required 0/1", run, irq);
        else passes++;
        axi_read(8'h04, 32'h1);
        axi_read(8'h28, 32'h1);
        axi_write(8'h04, 32'h1, 4'h1, 0, 0, 0, 0);
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_w1c: got %b, required 0", irq);
        else passes++;
        axi_read(8'h04, 32'h0);
    endtask

    task automatic test_shadow();
        axi_write(8'h00, 32'h5, 4'hF, 0, 0, 0, 0);
        axi_write(8'h10, 32'h140, 4'hF, 1, 0, 0, 0);
        tick();
        checks++;
        if (dst_width !== 32'h0000_FFFF) $display("FAIL dst_width_hold: got %h, required 0000ffff", dst_width);
        else passes++;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (dst_width !== 32'h140) $display("FAIL dst_width_frame_start: got %h, required 00000140", dst_width);
        else passes++;
        axi_write(8'h14, 32'h77, 4'hF, 0, 0, 0, 0);
        axi_write(8'h14, 32'hB4, 4'hF, 2, 1, 0, 0);
        checks++;
        if (dst_height !== 32'h77) $display("FAIL fs_vs_write: got %h, required 00000077", dst_height);
        else passes++;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (dst_height !== 32'hB4) $display("FAIL dst_height_next_frame: got %h, required 000000b4", dst_height);
        else passes++;
        pulse_done();
        checks++;
        if (run !== 1'b1) $display("FAIL run_continuous: got %b, required 1", run);
        else passes++;
        axi_read(8'h28, 32'h2);
        axi_write(8'h00, 32'h0, 4'hF, 0, 0, 0, 0);
    endtask

    task automatic test_logo();
        axi_write(8'h50, 32'h20, 4'hF, 0, 0, 0, 0);
        checks++;
        if (logo_hbegin !== 64'h0000_0020_0000_0000)
            $display("FAIL logo1_hbegin: got %h, required 0000002000000000", logo_hbegin);
        else passes++;
        axi_read(8'h50, 32'h20);
        axi_write(8'h60, 32'h55, 4'hF, 0, 0, 0, 0);
        axi_read(8'h60, 32'h0);
        axi_write(8'h00, 32'h200, 4'hF, 0, 0, 0, 0);
        checks++;
        if (logo_valid !== 2'b10) $display("FAIL logo_valid: got %b, required 10", logo_valid);
        else passes++;
        axi_read(8'h00, 32'h200);
        axi_read(8'h2C, 32'h0);
    endtask

    task automatic test_done_w1c_race();
        axi_write(8'h00, 32'h10, 4'hF, 0, 0, 0, 0);
        pulse_done();
        axi_write(8'h04, 32'h1, 4'h1, 0, 0, 1, 0);
        checks++;
        if (irq !== 1'b1) $display("FAIL race_irq: got %b, required 1", irq);
        else passes++;
        axi_read(8'h04, 32'h1);
        axi_read(8'h28, 32'h4);
    endtask

    task automatic test_soft_reset();
        axi_write(8'h00, 32'h13, 4'hF, 0, 0, 0, 0);
        checks++;
        if (sr_at_commit !== 1'b1 || sr_after !== 1'b0 || run !== 1'b0 || irq !== 1'b0)
            $display("FAIL soft_reset_pulse: sr=%b,%b run=%b irq=%b, required 1,0 0 0",
                     sr_at_commit, sr_after, run, irq);
        else passes++;
        axi_read(8'h00, 32'h10);
        axi_read(8'h04, 32'h0);
        axi_read(8'h28, 32'h0);
    endtask

    task automatic test_reset_mid();
        axi_write(8'h08, 32'h99, 4'hF, 0, 0, 0, 0);
        axi_write(8'h0C, 32'h12, 4'hF, 0, 0, 0, 1);
        reset = 1'b1;
        tick();
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || src_width !== 32'h0)
            $display("FAIL reset_mid: bvalid=%b awready=%b src_w=%h, required 0/1/00000000",
                     S_AXI_BVALID, S_AXI_AWREADY, src_width);
        else passes++;
        reset = 1'b0;
        axi_read(8'h08, 32'h0);
        axi_read(8'h00, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        done = 1'b0; frame_start = 1'b0;
        hlocation_in = 32'h0000_1234; vlocation_in = 32'h0000_0056;
        hlocation_out = 32'h0000_0789; vlocation_out = 32'h0000_0012;
        sr_at_commit = 1'b0; sr_after = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        test_reset();
        test_aw_before_w();
        test_wstrb();
        test_done_irq();
        test_shadow();
        test_logo();
        test_done_w1c_race();
        test_soft_reset();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
        else passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
